// File: rtl/next_pc.sv
// Next-PC selector for the single-cycle MIPS fetch unit: sequential, branch, jump or jr target.
// Optional sticky misaligned-target flag built only when NEXTPC_ALIGN_CHECK_EN is defined.
module next_pc #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] oldPC,
  input  logic [31:0] imm32,
  input  logic [25:0] addr26,
  input  logic [31:0] ra32,
  input  logic [1:0]  PC_mux,
  output logic [31:0] newPC,
  output logic [31:0] pc_plus4
`ifdef NEXTPC_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_REG    = 2'b11
  } pc_sel_e;

  pc_sel_e     pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] selected_pc;

  assign pc_sel        = pc_sel_e'(PC_mux);
  assign pc_plus4      = oldPC + 32'd4;
  // The word offset's top two bits fall off the shift; wrap handles negative offsets.
  assign branch_target = pc_plus4 + {imm32[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], addr26, 2'b00};

  always_comb begin
    selected_pc = pc_plus4;
    unique case (pc_sel)
      SEL_SEQ:    selected_pc = pc_plus4;
      SEL_BRANCH: selected_pc = branch_target;
      SEL_JUMP:   selected_pc = jump_target;
      SEL_REG:    selected_pc = ra32;
    endcase
  end

  // Reset vector overrides the target combinationally, no clock edge involved.
  assign newPC = reset ? selected_pc : RESET_PC;

`ifdef NEXTPC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if (selected_pc[1:0] != 2'b00) begin
      addr_err <= 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, imm32[31:30]};
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, clk, imm32[31:30]};
`endif

endmodule

// File: tb/tb_next_pc.sv
// Self-checking bench for next_pc: directed vector table, hand-written reset/flag sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_next_pc;

  logic        clk;
  logic        reset;
  logic [31:0] oldPC;
  logic [31:0] imm32;
  logic [25:0] addr26;
  logic [31:0] ra32;
  logic [1:0]  PC_mux;
  logic [31:0] newPC;
  logic [31:0] pc_plus4;
`ifdef NEXTPC_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int num_checks = 0;
  int num_errors = 0;

  next_pc #(.RESET_PC(32'h00003000)) dut (
    .clk      (clk),
    .reset    (reset),
    .oldPC    (oldPC),
    .imm32    (imm32),
    .addr26   (addr26),
    .ra32     (ra32),
    .PC_mux   (PC_mux),
    .newPC    (newPC),
    .pc_plus4 (pc_plus4)
`ifdef NEXTPC_ALIGN_CHECK_EN
    ,
    .addr_err (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] old_pc;
    logic [31:0] imm;
    logic [25:0] a26;
    logic [31:0] ra;
    logic [1:0]  sel;
    logic [31:0] exp_new;
    logic [31:0] exp_plus4;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    reset  = v.rst;
    oldPC  = v.old_pc;
    imm32  = v.imm;
    addr26 = v.a26;
    ra32   = v.ra;
    PC_mux = v.sel;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model written from the selection rules with plain arithmetic.
  function automatic logic [31:0] model_new_pc(input logic rst, input logic [31:0] old_pc,
                                               input logic [31:0] imm, input logic [25:0] a26,
                                               input logic [31:0] ra, input logic [1:0] sel);
    logic [31:0] plus4;
    plus4 = old_pc + 32'd4;
    if (!rst) return 32'h00003000;
    case (sel)
      2'd0:    return plus4;
      2'd1:    return plus4 + imm * 32'd4;
      2'd2:    return (plus4 & 32'hF0000000) + {6'd0, a26} * 32'd4;
      default: return ra;
    endcase
  endfunction

  function automatic vec_t mk(input string name, input logic rst, input logic [31:0] old_pc,
                              input logic [31:0] imm, input logic [25:0] a26,
                              input logic [31:0] ra, input logic [1:0] sel,
                              input logic [31:0] exp_new, input logic [31:0] exp_plus4);
    vec_t v;
    v.name = name; v.rst = rst; v.old_pc = old_pc; v.imm = imm; v.a26 = a26;
    v.ra = ra; v.sel = sel; v.exp_new = exp_new; v.exp_plus4 = exp_plus4;
    return v;
  endfunction

  logic        model_err;
  logic [31:0] exp_new;
  vec_t        rv;

  initial begin
    vecs.push_back(mk("seq",         1, 32'h00003000, 0,            0,         0,            2'b00, 32'h00003004, 32'h00003004));
    vecs.push_back(mk("branch_back", 1, 32'h00003000, 32'hFFFFFFFF, 0,         0,            2'b01, 32'h00003000, 32'h00003004));
    vecs.push_back(mk("branch_fwd",  1, 32'h00003000, 32'd3,        0,         0,            2'b01, 32'h00003010, 32'h00003004));
    vecs.push_back(mk("branch_msb",  1, 32'h00003000, 32'hC0000001, 0,         0,            2'b01, 32'h00003008, 32'h00003004));
    vecs.push_back(mk("jump",        1, 32'h00003000, 0,            26'h0000C03, 0,          2'b10, 32'h0000300C, 32'h00003004));
    vecs.push_back(mk("jump_wrap",   1, 32'hFFFFFFFC, 0,            26'd1,     0,            2'b10, 32'h00000004, 32'h00000000));
    vecs.push_back(mk("jump_nibble", 1, 32'h8FFFFFFC, 0,            26'd2,     0,            2'b10, 32'h90000008, 32'h90000000));
    vecs.push_back(mk("jr",          1, 32'h00003000, 0,            0,         32'h00003010, 2'b11, 32'h00003010, 32'h00003004));
    vecs.push_back(mk("seq_wrap",    1, 32'hFFFFFFFC, 0,            0,         0,            2'b00, 32'h00000000, 32'h00000000));
    vecs.push_back(mk("reset_jr",    0, 32'h00004000, 0,            0,         32'h12345678, 2'b11, 32'h00003000, 32'h00004004));

    reset = 1'b0; oldPC = 0; imm32 = 0; addr26 = 0; ra32 = 0; PC_mux = 0;
    #1;
    checkOutput("reset_newPC", newPC, 32'h00003000);
`ifdef NEXTPC_ALIGN_CHECK_EN
    checkOutput("reset_addr_err", {31'd0, addr_err}, 32'd0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, "_newPC"}, newPC, vecs[i].exp_new);
      checkOutput({vecs[i].name, "_plus4"}, pc_plus4, vecs[i].exp_plus4);
    end

    // Reset override asserts and releases with no clock edge in between.
    @(negedge clk);
    reset = 1'b1; PC_mux = 2'b11; ra32 = 32'h12345678;
    #1 reset = 1'b0;
    #1 checkOutput("async_reset_assert", newPC, 32'h00003000);
    reset = 1'b1;
    #1 checkOutput("async_reset_release", newPC, 32'h12345678);

`ifdef NEXTPC_ALIGN_CHECK_EN
    @(negedge clk);
    reset = 1'b0;
    #1 reset = 1'b1;
    PC_mux = 2'b11; ra32 = 32'h00003002;
    #1 checkOutput("err_before_edge", {31'd0, addr_err}, 32'd0);
    @(posedge clk); #1;
    checkOutput("err_after_edge", {31'd0, addr_err}, 32'd1);
    @(negedge clk);
    ra32 = 32'h00003010;
    @(posedge clk); #1;
    checkOutput("err_sticky", {31'd0, addr_err}, 32'd1);
    reset = 1'b0;
    #1 checkOutput("err_async_clear", {31'd0, addr_err}, 32'd0);
    ra32 = 32'h00003001;
    @(posedge clk); #1;
    checkOutput("err_held_in_reset", {31'd0, addr_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("err_first_edge_after_release", {31'd0, addr_err}, 32'd1);
`endif

    @(negedge clk);
    reset = 1'b0;
    #1 reset = 1'b1;
    model_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rv.name   = "rand";
      rv.rst    = ($urandom_range(0, 15) != 0);
      rv.old_pc = $urandom;
      if ($urandom_range(0, 7) != 0) rv.old_pc[1:0] = 2'b00;
      rv.imm    = $urandom;
      rv.a26    = 26'($urandom);
      rv.ra     = $urandom;
      if ($urandom_range(0, 7) != 0) rv.ra[1:0] = 2'b00;
      rv.sel    = 2'($urandom_range(0, 3));
      applyStimulus(rv);
      if (!rv.rst) model_err = 1'b0;
      exp_new = model_new_pc(rv.rst, rv.old_pc, rv.imm, rv.a26, rv.ra, rv.sel);
      #1;
      checkOutput("rand_newPC", newPC, exp_new);
      checkOutput("rand_plus4", pc_plus4, rv.old_pc + 32'd4);
`ifdef NEXTPC_ALIGN_CHECK_EN
      checkOutput("rand_addr_err", {31'd0, addr_err}, {31'd0, model_err});
`endif
      @(posedge clk);
      if (rv.rst && (exp_new % 4 != 0)) model_err = 1'b1;
      if (($urandom_range(0, 31) == 0) && rv.rst) begin
        #1 reset = 1'b0;
        model_err = 1'b0;
        #1 reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
